// File: rtl/i2c_wr_master.sv
// i2c_wr_master: write-only I2C master sending {addr,W}, data[15:8], data[7:0] per request.
// Define ACK_CHECK_EN to abort to STOP and raise i2c_ack when the slave NACKs any byte.
module i2c_wr_master #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned I2C_FREQ   = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic [15:0] i2c_data,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        i2c_busy,
  output logic        scl,
  output logic        sda_o,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int unsigned QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

  if (QDIV < 1) begin : g_qdiv_check
    $error("i2c_wr_master: CLK_FREQ/(4*I2C_FREQ) must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StStart, StSend, StAck, StStop, StDone} state_e;

  state_e          r_state;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [1:0]      r_byte;
  logic [15:0]     r_data;
  logic            r_scl, r_sda_oe, r_done, r_ack, r_busy;
  logic            r_sda_s1, r_sda_s2;

  logic            w_tick, w_run, w_next_bit, w_next_msb, w_nack;
  logic [7:0]      w_byte;

  assign w_run  = (r_state != StIdle) && (r_state != StDone);
  assign w_tick = w_run && (r_qcnt == QW'(QDIV - 1));

`ifdef ACK_CHECK_EN
  assign w_nack = r_sda_s2;
`else
  logic w_unused_sda;
  assign w_unused_sda = r_sda_s2;
  assign w_nack       = 1'b0;
`endif

  always_comb begin
    w_byte = r_data[7:0];
    case (r_byte)
      2'd0:    w_byte = {SLAVE_ADDR, 1'b0};
      2'd1:    w_byte = r_data[15:8];
      default: ;
    endcase
    w_next_bit = w_byte[r_bit - 3'd1];
    w_next_msb = (r_byte == 2'd0) ? r_data[15] : r_data[7];
  end

  // Each tick moves to the next quarter; outputs are set for the quarter being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_qcnt   <= '0;
      r_q      <= 2'd0;
      r_bit    <= 3'd7;
      r_byte   <= 2'd0;
      r_data   <= 16'h0000;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_done   <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_done   <= 1'b0;
      if (!w_run || w_tick) r_qcnt <= '0;
      else                  r_qcnt <= r_qcnt + QW'(1);
      if (w_tick) r_q <= r_q + 2'd1;

      case (r_state)
        StIdle: if (i2c_exec) begin
          r_data   <= i2c_data;
          r_byte   <= 2'd0;
          r_bit    <= 3'd7;
          r_q      <= 2'd0;
          r_ack    <= 1'b0;
          r_busy   <= 1'b1;
          r_scl    <= 1'b1;
          r_sda_oe <= 1'b0;
          r_state  <= StStart;
        end
        StStart: if (w_tick) begin
          case (r_q)
            2'd0: r_sda_oe <= 1'b1;
            2'd2: r_scl    <= 1'b0;
            2'd3: begin
              r_sda_oe <= ~w_byte[7];
              r_state  <= StSend;
            end
            default: ;
          endcase
        end
        StSend: if (w_tick) begin
          case (r_q)
            2'd0: r_scl <= 1'b1;
            2'd2: r_scl <= 1'b0;
            2'd3: begin
              if (r_bit == 3'd0) begin
                r_sda_oe <= 1'b0;
                r_state  <= StAck;
              end else begin
                r_bit    <= r_bit - 3'd1;
                r_sda_oe <= ~w_next_bit;
              end
            end
            default: ;
          endcase
        end
        StAck: if (w_tick) begin
          case (r_q)
            2'd0: r_scl <= 1'b1;
            2'd2: begin
              r_scl <= 1'b0;
              if (w_nack) r_ack <= 1'b1;
            end
            2'd3: begin
              if (r_ack || r_byte == 2'd2) begin
                r_sda_oe <= 1'b1;
                r_state  <= StStop;
              end else begin
                r_byte   <= r_byte + 2'd1;
                r_bit    <= 3'd7;
                r_sda_oe <= ~w_next_msb;
                r_state  <= StSend;
              end
            end
            default: ;
          endcase
        end
        StStop: if (w_tick) begin
          case (r_q)
            2'd0: r_scl    <= 1'b1;
            2'd1: r_sda_oe <= 1'b0;
            2'd3: begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end
            default: ;
          endcase
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign i2c_done = r_done;
  assign i2c_ack  = r_ack;
  assign i2c_busy = r_busy;
  assign scl      = r_scl;
  assign sda_o    = 1'b0;
  assign sda_oe   = r_sda_oe;

endmodule

// File: tb/tb_i2c_wr_master.sv
// tb_i2c_wr_master: directed bench with a byte-collecting I2C slave model on an open-drain SDA.
`timescale 1ns/1ps
module tb_i2c_wr_master;

  localparam int unsigned QDIV      = 4;
  localparam int unsigned XFER_CLKS = 29 * 4 * QDIV;

  logic        clk = 1'b0, rst_n = 1'b0, i2c_exec = 1'b0;
  logic [15:0] i2c_data = 16'h0000;
  logic        i2c_done, i2c_ack, i2c_busy, scl, sda_o, sda_oe, sda_i;
  logic        slv_pull = 1'b0;
  logic        sda_bus;

  assign sda_bus = ~((sda_oe & ~sda_o) | slv_pull);
  assign sda_i   = sda_bus;

  i2c_wr_master #(
    .SLAVE_ADDR(7'h1A),
    .CLK_FREQ  (4_000_000),
    .I2C_FREQ  (250_000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i2c_exec(i2c_exec),
    .i2c_data(i2c_data),
    .i2c_done(i2c_done),
    .i2c_ack (i2c_ack),
    .i2c_busy(i2c_busy),
    .scl     (scl),
    .sda_o   (sda_o),
    .sda_oe  (sda_oe),
    .sda_i   (sda_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, n_start = 0, n_stop = 0, n_viol = 0, n_scl_edges = 0;
  int bitn = 0, byte_idx = 0, nack_byte = -1;
  logic       active = 1'b0, mon_en = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk) if (i2c_done === 1'b1) done_cnt++;
  always @(scl) n_scl_edges++;

  // Slave: shift on SCL rise, ACK by pulling SDA from the 8th fall to the 9th fall.
  always @(posedge scl) if (mon_en && active) begin
    shreg = {shreg[6:0], sda_bus};
    bitn++;
  end
  always @(negedge scl) if (mon_en && active) begin
    if (bitn == 8) begin
      rx_q.push_back(shreg);
      slv_pull = (byte_idx != nack_byte);
    end else if (bitn == 9) begin
      slv_pull = 1'b0;
      bitn = 0;
      byte_idx++;
    end
  end
  // STOP shows up as one stray SCL rise (bitn==1) followed by SDA rising.
  always @(sda_bus) if (mon_en && scl === 1'b1) begin
    if (sda_bus === 1'b0 && !active) begin
      active = 1'b1; bitn = 0; byte_idx = 0; n_start++;
    end else if (sda_bus === 1'b1 && active && bitn == 1) begin
      active = 1'b0; bitn = 0; n_stop++;
    end else begin
      n_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [15:0] d);
    @(negedge clk);
    i2c_data = d;
    i2c_exec = 1'b1;
    @(posedge clk);
    #1;
    i2c_exec = 1'b0;
    chk("busy_after_accept", i2c_busy, 1);
  endtask

  task automatic wait_done(output int cyc);
    bit ok = 0;
    cyc = 0;
    while (cyc < 200 * QDIV) begin
      @(posedge clk);
      cyc++;
      #1;
      if (i2c_done === 1'b1) begin ok = 1; break; end
    end
    chk("done_seen", ok, 1);
    chk("busy_low_at_done", i2c_busy, 0);
    @(posedge clk);
    #1;
    chk("done_one_clk", i2c_done, 0);
  endtask

  task automatic check_bytes(input string tag, input logic [23:0] exp, input int n);
    chk({tag, "_nbytes"}, rx_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rx_q.size()) chk({tag, "_byte"}, {24'h0, rx_q[i]}, {24'h0, exp[23-8*i -: 8]});
  endtask

  task automatic run(input string tag, input logic [15:0] d, input logic [23:0] exp, input int n,
                     input logic exp_ack, input bit chk_time);
    int cyc, d0, s0;
    rx_q.delete();
    d0 = done_cnt;
    s0 = n_stop;
    start_xfer(d);
    wait_done(cyc);
    if (chk_time) chk({tag, "_cycles"}, cyc, XFER_CLKS);
    check_bytes(tag, exp, n);
    chk({tag, "_ack"}, i2c_ack, exp_ack);
    chk({tag, "_stops"}, n_stop - s0, 1);
    chk({tag, "_dones"}, done_cnt - d0, 1);
  endtask

  initial begin
    int e0, d0, s0, cyc;
    logic [15:0] d;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_done", i2c_done, 0);
    chk("rst_busy", i2c_busy, 0);
    chk("rst_ack", i2c_ack, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    e0 = n_scl_edges;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_scl_edges", n_scl_edges - e0, 0);
    chk("idle_sda_oe", sda_oe, 0);
    chk("idle_busy", i2c_busy, 0);

    // reg 0x06, d8=0, data 0x6F -> wire bytes 0x34, 0x0C, 0x6F
    run("basic", 16'h0C6F, 24'h340C6F, 3, 1'b0, 1'b1);

    nack_byte = 1;
`ifdef ACK_CHECK_EN
    run("nack1", 16'h0C6F, 24'h340C00, 2, 1'b1, 1'b0);
`else
    run("nack1", 16'h0C6F, 24'h340C6F, 3, 1'b0, 1'b1);
`endif
    nack_byte = -1;
    run("after_nack", 16'hFF01, 24'h34FF01, 3, 1'b0, 1'b1);

    // Sequencer loop: each request issued right after the previous done
    d0 = done_cnt;
    for (int i = 0; i < 19; i++) begin
      d = {7'(i + 1), 9'(i * 29 + 3)};
      run("loop", d, {8'h34, d}, 3, 1'b0, 1'b0);
    end
    chk("loop_dones", done_cnt - d0, 19);
    chk("no_sda_edge_scl_high", n_viol, 0);

    // exec while busy is ignored
    rx_q.delete();
    d0 = done_cnt;
    s0 = n_stop;
    start_xfer(16'h1234);
    repeat (40) @(negedge clk);
    i2c_data = 16'hABCD;
    i2c_exec = 1'b1;
    @(negedge clk);
    i2c_exec = 1'b0;
    wait_done(cyc);
    check_bytes("busy_exec", 24'h341234, 3);
    repeat (200) @(posedge clk);
    #1;
    chk("busy_exec_dones", done_cnt - d0, 1);
    chk("busy_exec_stops", n_stop - s0, 1);

    // Reset in the middle of byte 1
    rx_q.delete();
    start_xfer(16'h5A3C);
    repeat (56 * QDIV) @(negedge clk);
    chk("pre_rst_busy", i2c_busy, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_scl", scl, 1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", i2c_busy, 0);
    active   = 1'b0;
    bitn     = 0;
    slv_pull = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run("post_rst", 16'h5A3C, 24'h345A3C, 3, 1'b0, 1'b1);
    chk("final_no_viol", n_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
